// File: rtl/audio_fx_engine.sv
// Multi-channel codec effects engine: silence, shared sine tone, passthrough and echo modes.
// Optional feature: define AUDIO_FX_ECHO_EN to build the per-channel echo buffers (else mode 11 = passthrough).
module audio_fx_engine #(
  parameter int          DATA_W      = 16,
  parameter int          NUM_CH      = 2,
  parameter int          DELAY_DEPTH = 1024,
  parameter logic [15:0] TONE_STEP   = 16'd1486
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sample_end,
  input  logic [NUM_CH-1:0] sample_req,
  input  logic [DATA_W-1:0] audio_input,
  output logic [DATA_W-1:0] audio_output,
  input  logic [3:0]        control
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic signed [DATA_W-1:0] in_reg [NUM_CH];
  logic [15:0]              phase;
  logic [CH_W-1:0]          sel_ch;
  logic                     req_any;
  logic signed [DATA_W-1:0] cur_in;
  logic signed [DATA_W-1:0] tone_val;
  logic signed [DATA_W-1:0] echo_val;
  logic signed [DATA_W-1:0] mode_val;
  logic signed [DATA_W-1:0] att_val;

  // Full-period sine derived from one quarter wave by symmetry, amplitude 32767, rescaled to DATA_W.
  function automatic logic signed [DATA_W-1:0] sine_rom(input logic [5:0] idx);
    logic [5:0]         mirror;
    logic [4:0]         q;
    logic [15:0]        mag;
    logic signed [15:0] s;
    mirror = 6'd32 - {1'b0, idx[4:0]};
    q      = (idx[4:0] > 5'd16) ? mirror[4:0] : idx[4:0];
    case (q)
      5'd0:    mag = 16'd0;
      5'd1:    mag = 16'd3212;
      5'd2:    mag = 16'd6393;
      5'd3:    mag = 16'd9512;
      5'd4:    mag = 16'd12539;
      5'd5:    mag = 16'd15446;
      5'd6:    mag = 16'd18204;
      5'd7:    mag = 16'd20787;
      5'd8:    mag = 16'd23170;
      5'd9:    mag = 16'd25329;
      5'd10:   mag = 16'd27245;
      5'd11:   mag = 16'd28898;
      5'd12:   mag = 16'd30273;
      5'd13:   mag = 16'd31356;
      5'd14:   mag = 16'd32137;
      5'd15:   mag = 16'd32609;
      5'd16:   mag = 16'd32767;
      default: mag = 16'd0;
    endcase
    s = idx[5] ? -signed'(mag) : signed'(mag);
    return DATA_W'(((DATA_W+16)'(s) <<< DATA_W) >>> 16);
  endfunction

  always_comb begin
    sel_ch  = '0;
    req_any = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (sample_req[c]) begin
        sel_ch  = CH_W'(c);
        req_any = 1'b1;
      end
    end
  end

  assign cur_in   = in_reg[sel_ch];
  assign tone_val = sine_rom(phase[15:10]);

`ifdef AUDIO_FX_ECHO_EN
  localparam int PTR_W = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;

  logic signed [DATA_W-1:0] echo_mem [NUM_CH][DELAY_DEPTH];
  logic [PTR_W-1:0]         wr_ptr   [NUM_CH];
  logic [NUM_CH-1:0]        filled;
  logic signed [DATA_W-1:0] delayed  [NUM_CH];
  logic signed [DATA_W-1:0] half;
  logic [DATA_W:0]          sum;

  // The slot about to be overwritten holds the sample from DELAY_DEPTH writes ago, so grab it on write.
  always_ff @(posedge clk) begin
    if (reset) begin
      filled <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]  <= '0;
        delayed[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sample_end[c]) begin
          delayed[c] <= filled[c] ? echo_mem[c][wr_ptr[c]] : '0;
          wr_ptr[c]  <= wr_ptr[c] + PTR_W'(1);
          if (wr_ptr[c] == PTR_W'(DELAY_DEPTH - 1))
            filled[c] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (sample_end[c] && !reset)
        echo_mem[c][wr_ptr[c]] <= audio_input;
    end
  end

  always_comb begin
    half     = delayed[sel_ch] >>> 1;
    sum      = {cur_in[DATA_W-1], cur_in} + {half[DATA_W-1], half};
    echo_val = sum[DATA_W-1:0];
    if (sum[DATA_W] != sum[DATA_W-1])
      echo_val = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign echo_val = cur_in;
`endif

  always_comb begin
    case (control[1:0])
      2'b00:   mode_val = '0;
      2'b01:   mode_val = tone_val;
      2'b10:   mode_val = cur_in;
      default: mode_val = echo_val;
    endcase
    att_val = mode_val >>> control[3:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      audio_output <= '0;
      phase        <= '0;
      for (int c = 0; c < NUM_CH; c++)
        in_reg[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sample_end[c])
          in_reg[c] <= audio_input;
      end
      if (req_any)
        audio_output <= att_val;
      if (sample_req[0])
        phase <= phase + TONE_STEP;
    end
  end

endmodule

// File: tb/tb_audio_fx_engine.sv
// Directed bench for audio_fx_engine: vector table for passthrough/attenuation, hand sequences for tone, echo and reset.
module tb_audio_fx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sample_end;
  logic [1:0]  sample_req;
  logic [15:0] audio_input;
  logic [15:0] audio_output;
  logic [3:0]  control;

  int checks = 0;
  int fails  = 0;

`ifdef AUDIO_FX_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  typedef struct {
    logic [1:0]  end_mask;
    logic [1:0]  req_mask;
    logic [15:0] din;
    logic [3:0]  ctrl;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [13];

  audio_fx_engine #(
    .DATA_W(16), .NUM_CH(2), .DELAY_DEPTH(4), .TONE_STEP(16'h0400)
  ) dut (
    .clk(clk), .reset(reset), .sample_end(sample_end), .sample_req(sample_req),
    .audio_input(audio_input), .audio_output(audio_output), .control(control)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic [1:0] em, input logic [1:0] rm,
                                input logic [15:0] din, input logic [3:0] ctrl);
    sample_end  = em;
    sample_req  = rm;
    audio_input = din;
    control     = ctrl;
    @(posedge clk);
    #1;
    sample_end = 2'b00;
    sample_req = 2'b00;
  endtask

  task automatic check_output(input string name, input logic [15:0] exp);
    checks++;
    if (audio_output !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, audio_output, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_stimulus(2'b00, 2'b00, 16'h0000, 4'b0000);
    apply_stimulus(2'b00, 2'b00, 16'h0000, 4'b0000);
    reset = 1'b0;
  endtask

  initial begin
    // Passthrough / attenuation / arbitration / same-cycle vectors
    vecs[0]  = '{2'b10, 2'b00, 16'h1234, 4'b0010, 16'h0000};
    vecs[1]  = '{2'b00, 2'b10, 16'h0000, 4'b0010, 16'h1234};
    vecs[2]  = '{2'b01, 2'b00, 16'h8000, 4'b0010, 16'h1234};
    vecs[3]  = '{2'b00, 2'b01, 16'h0000, 4'b1010, 16'hE000};
    vecs[4]  = '{2'b00, 2'b11, 16'h0000, 4'b0010, 16'h8000};
    vecs[5]  = '{2'b00, 2'b10, 16'h0000, 4'b0110, 16'h091A};
    vecs[6]  = '{2'b00, 2'b10, 16'h0000, 4'b0000, 16'h0000};
    vecs[7]  = '{2'b00, 2'b01, 16'h0000, 4'b1110, 16'hF000};
    vecs[8]  = '{2'b01, 2'b00, 16'h0003, 4'b0010, 16'hF000};
    vecs[9]  = '{2'b01, 2'b01, 16'h0005, 4'b0010, 16'h0003};
    vecs[10] = '{2'b00, 2'b01, 16'h0000, 4'b0010, 16'h0005};
    vecs[11] = '{2'b11, 2'b00, 16'h7FFF, 4'b0010, 16'h0005};
    vecs[12] = '{2'b00, 2'b10, 16'h0000, 4'b0010, 16'h7FFF};

    sample_end  = 2'b00;
    sample_req  = 2'b00;
    audio_input = 16'h0000;
    control     = 4'b0000;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(2'b11, 2'b11, 16'h1111, 4'b0010);
    check_output("reset_out", 16'h0000);
    reset = 1'b0;
    apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0010);
    check_output("reset_end_ignored_ch0", 16'h0000);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].end_mask, vecs[i].req_mask, vecs[i].din, vecs[i].ctrl);
      check_output($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Tone: 64 ch0 requests walk one full ROM period with step 0x0400
    do_reset();
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0001);
      if (i == 0)  check_output("tone_idx0", 16'h0000);
      if (i == 8)  check_output("tone_idx8", 16'h5A82);
      if (i == 16) check_output("tone_idx16_peak", 16'h7FFF);
      if (i == 32) check_output("tone_idx32", 16'h0000);
      if (i == 48) check_output("tone_idx48_neg_peak", 16'h8001);
    end
    apply_stimulus(2'b00, 2'b10, 16'h0000, 4'b0001);
    check_output("tone_ch1_wrapped", 16'h0000);
    apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0001);
    check_output("tone_ch1_no_advance", 16'h0000);
    apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0001);
    check_output("tone_idx1", 16'h0C8C);

    // Echo: fill a 4-deep buffer, then saturating and normal echo sums
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'b01, 2'b00, 16'h4000, 4'b0011);
      apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0011);
      check_output($sformatf("echo_prefill%0d", i), 16'h4000);
    end
    apply_stimulus(2'b01, 2'b00, 16'h7000, 4'b0011);
    apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0011);
    check_output("echo_saturate", ECHO ? 16'h7FFF : 16'h7000);
    apply_stimulus(2'b01, 2'b00, 16'h1000, 4'b0011);
    apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0011);
    check_output("echo_sum", ECHO ? 16'h3000 : 16'h1000);
    apply_stimulus(2'b01, 2'b00, 16'h8000, 4'b0011);
    apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0011);
    check_output("echo_negative", ECHO ? 16'hA000 : 16'h8000);

    // Mid-stream reset: output clears, stale buffer contents stay masked
    reset = 1'b1;
    apply_stimulus(2'b01, 2'b01, 16'h5555, 4'b0011);
    check_output("echo_midreset_out", 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'b01, 2'b00, 16'h0100, 4'b0011);
      apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0011);
      check_output($sformatf("echo_postreset%0d", i), 16'h0100);
    end
    apply_stimulus(2'b01, 2'b00, 16'h0200, 4'b0011);
    apply_stimulus(2'b00, 2'b01, 16'h0000, 4'b0011);
    check_output("echo_postreset_wrap", ECHO ? 16'h0280 : 16'h0200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/audio_fx_engine.md
AUDIO_FX_ENGINE -- requirements
Module: audio_fx_engine

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 16, sample width in bits (signed two's complement).
REQ-002 The block SHALL provide parameter NUM_CH, default 2, number of codec channels served.
REQ-003 The block SHALL provide parameter DELAY_DEPTH, default 1024, echo samples per channel (power of two).
REQ-004 The block SHALL provide parameter TONE_STEP, default 16'd1486, phase increment per tone sample.
REQ-005 The block SHALL provide port clk, input, 1 bit, audio clock; all logic on its rising edge.
REQ-006 The block SHALL provide port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL provide port sample_end, input, NUM_CH bits, one-cycle pulse per channel: audio_input valid for that channel.
REQ-008 The block SHALL provide port sample_req, input, NUM_CH bits, one-cycle pulse per channel: codec requests next output sample.
REQ-009 The block SHALL provide port audio_input, input, DATA_W bits, captured sample.
REQ-010 The block SHALL provide port audio_output, output, DATA_W bits, registered playback sample.
REQ-011 The block SHALL provide port control, input, 4 bits: [1:0] mode, [3:2] attenuation shift.

Function
REQ-012 Modes SHALL be: 00 silence (output 0), 01 tone, 10 passthrough, 11 echo.
REQ-013 On sample_end[c], the block SHALL latch audio_input into channel c's input register; other channels are unchanged.
REQ-014 On sample_req[c], the block SHALL update audio_output exactly one cycle later and hold it until the next request.
REQ-015 If sample_end[c] and sample_req[c] coincide, the output SHALL use the previously latched sample for c.
REQ-016 If several sample_req bits are set in one cycle, the lowest-index channel SHALL be served and the others ignored.
REQ-017 Tone: a 16-bit phase accumulator SHALL advance by TONE_STEP on each sample_req[0] and wrap modulo 2^16.
REQ-018 The tone sample SHALL be a 64-entry full-period sine ROM indexed by phase[15:10], scaled to full DATA_W range; all channels share it.
REQ-019 Echo: each sample_end[c] SHALL write the latched sample to channel c's circular buffer at wr_ptr[c], and wr_ptr[c] SHALL wrap DELAY_DEPTH-1 -> 0.
REQ-020 The echo output SHALL be sat(in + (delayed >>> 1)), where delayed is the sample written DELAY_DEPTH writes earlier.
REQ-021 The sum SHALL be computed in DATA_W+1 bits and saturated to the signed DATA_W range.
REQ-022 A per-channel filled flag SHALL set on the first pointer wrap; while it is clear, delayed SHALL be treated as 0.
REQ-023 Attenuation SHALL arithmetic-right-shift the mode result by control[3:2] (0..3) after saturation.
REQ-024 control SHALL be sampled at each serviced sample_req; a mode change SHALL take effect on the next request without clearing the phase or the buffers.

Reset
REQ-025 While reset is high, audio_output, the input registers, the phase accumulator, wr_ptr and the filled flags SHALL all be 0.
REQ-026 Reset SHALL NOT clear the buffer RAM; the filled flags SHALL mask stale contents after a mid-operation reset.
REQ-027 Request and end pulses arriving in a reset cycle SHALL be ignored.

Configuration
REQ-028 With macro AUDIO_FX_ECHO_EN defined, the buffers, pointers and filled flags SHALL be built and mode 11 SHALL behave as specified.
REQ-029 Without AUDIO_FX_ECHO_EN, no buffer storage SHALL be inferred and mode 11 SHALL behave as passthrough.

Verification
REQ-030 Mode 10, ch1 sample_end with 16'h1234, then sample_req[1] -> audio_output = 16'h1234 one cycle later.
REQ-031 Mode 01, 64 requests with TONE_STEP = 16'h0400 -> one full ROM period; output 0 at index 0, +peak at index 16, -peak at index 48.
REQ-032 Mode 11 with ECHO_EN and DELAY_DEPTH = 4: inputs 16'h4000 x4, then 16'h7000 -> output 16'h7FFF (saturated); before the first wrap, output equals the input.
REQ-033 Mode 10, control[3:2] = 2, input 16'h8000 -> output 16'hE000.
REQ-034 Assert reset mid-stream in mode 11, then resume -> output 0 during reset; afterwards, output equals the input until DELAY_DEPTH new writes have occurred.
REQ-035 Same-cycle sample_end[0] = 16'h0005 and sample_req[0] after prior sample 16'h0003 -> output 16'h0003; the next request -> 16'h0005.
